// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for the D/X stage, with a DEPTH-entry destination-tag pipeline.
// Latency: selects, mem_fwd and stall are combinational from inputs and tags; tags move on advance.
// Backpressure: advance=0 freezes tags and FSM; optional stall_cnt under FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 2,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dx_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] dx_rs,
  input  logic [NUM_SRC-1:0]        dx_rs_use,
  input  logic [ADDR_W-1:0]         dx_rd,
  input  logic                      dx_we,
  input  logic                      dx_is_load,
  input  logic                      dx_is_store,
  input  logic                      advance,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      mem_fwd,
  output logic                      stall,
  output logic                      bubble
`ifdef FWD_STALL_CNT_EN
  , output logic [31:0]             stall_cnt
`endif
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic              isLoad;
    logic              isStore;
  } tag_t;

  typedef enum logic {RUN, STALL} state_t;

  tag_t   tags [1:DEPTH];
  state_t state, stateNxt;

  logic [NUM_SRC*DEPTH-1:0] hit;
  logic [NUM_SRC*SEL_W-1:0] selRaw;
  logic                     loadUse;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      assign hit[i*DEPTH + k - 1] = tags[k].vld && tags[k].we && dx_rs_use[i] && dx_valid
                                    && (tags[k].rd == dx_rs[i*ADDR_W +: ADDR_W])
                                    && (tags[k].rd != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the last write.
  always_comb begin
    selRaw  = '0;
    loadUse = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (hit[i*DEPTH + k - 1]) selRaw[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
      loadUse = loadUse | (hit[i*DEPTH] & tags[1].isLoad);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= stateNxt;
  end

  // A stall is only raised from RUN, so it never lasts beyond one advancing cycle.
  always_comb begin
    stateNxt = state;
    stall    = 1'b0;
    case (state)
      RUN: begin
        stall = loadUse;
        if (loadUse && advance) stateNxt = STALL;
      end
      STALL: begin
        if (advance) stateNxt = RUN;
      end
      default: stateNxt = RUN;
    endcase
  end

  assign bubble  = stall;
  assign fwd_sel = stall ? '0 : selRaw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++) tags[k] <= '0;
    end else if (advance) begin
      tags[1] <= '{vld: dx_valid & ~stall, rd: dx_rd, we: dx_we,
                   isLoad: dx_is_load, isStore: dx_is_store};
      for (int k = 2; k <= DEPTH; k++) tags[k] <= tags[k-1];
    end
  end

  if (DEPTH >= 2) begin : g_memfwd
    assign mem_fwd = tags[1].vld && tags[1].isStore && tags[2].vld && tags[2].we
                     && (tags[1].rd == tags[2].rd) && (tags[1].rd != '0);
  end else begin : g_nomemfwd
    assign mem_fwd = 1'b0;
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        stall_cnt <= '0;
    else if (stall && advance && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a list-of-instructions reference model.
module tb_fwd_hazard_ctrl;

  localparam int NUM_SRC = 2;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = 2;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      dx_valid;
  logic [NUM_SRC*ADDR_W-1:0] dx_rs;
  logic [NUM_SRC-1:0]        dx_rs_use;
  logic [ADDR_W-1:0]         dx_rd;
  logic                      dx_we, dx_is_load, dx_is_store, advance;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      mem_fwd, stall, bubble;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]               stall_cnt;
`endif

  fwd_hazard_ctrl #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dx_valid(dx_valid), .dx_rs(dx_rs),
    .dx_rs_use(dx_rs_use), .dx_rd(dx_rd), .dx_we(dx_we), .dx_is_load(dx_is_load),
    .dx_is_store(dx_is_store), .advance(advance), .fwd_sel(fwd_sel),
    .mem_fwd(mem_fwd), .stall(stall), .bubble(bubble)
`ifdef FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the instructions currently sitting in each downstream stage.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
    bit st;
  } ent_t;

  ent_t mdl [1:DEPTH];
  bit   prevStalled;   // the last advancing cycle was a load-use stall
  int   mdlCnt;

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int k = 1; k <= DEPTH; k++) mdl[k] = '{0, 0, 0, 0, 0};
    prevStalled = 0;
    mdlCnt      = 0;
  endtask

  function automatic void expOut(output logic [NUM_SRC*SEL_W-1:0] eSel,
                                 output logic eMem, output logic eStall);
    int sel [NUM_SRC];
    int rs;
    bit lu;
    lu = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = 0;
      rs = int'(dx_rs[i*ADDR_W +: ADDR_W]);
      for (int k = 1; k <= DEPTH; k++) begin
        if (sel[i] == 0 && mdl[k].v && mdl[k].we && mdl[k].rd == rs && rs != 0
            && dx_rs_use[i] && dx_valid) begin
          sel[i] = k;
          if (k == 1 && mdl[1].ld) lu = 1;
        end
      end
    end
    eStall = lu && !prevStalled;
    eSel = '0;
    if (!eStall)
      for (int i = 0; i < NUM_SRC; i++) eSel[i*SEL_W +: SEL_W] = SEL_W'(sel[i]);
    eMem = mdl[1].v && mdl[1].st && mdl[2].v && mdl[2].we
           && mdl[1].rd == mdl[2].rd && mdl[1].rd != 0;
  endfunction

  logic [NUM_SRC*SEL_W-1:0] cSel, uSel;
  logic cMem, cStall, uMem, uStall;

  always @(negedge clock) begin
    if (checkEn) begin
      expOut(cSel, cMem, cStall);
      chk("model fwd_sel", 32'(fwd_sel), 32'(cSel));
      chk("model mem_fwd", 32'(mem_fwd), 32'(cMem));
      chk("model stall",   32'(stall),   32'(cStall));
      chk("model bubble",  32'(bubble),  32'(cStall));
`ifdef FWD_STALL_CNT_EN
      chk("model stall_cnt", stall_cnt, 32'(mdlCnt));
`endif
    end
  end

  always @(posedge clock) begin
    if (reset === 1'b1 && advance) begin
      expOut(uSel, uMem, uStall);
      for (int k = DEPTH; k >= 2; k--) mdl[k] = mdl[k-1];
      mdl[1] = '{dx_valid && !uStall, int'(dx_rd), dx_we, dx_is_load, dx_is_store};
      prevStalled = uStall;
      if (uStall) mdlCnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] use_,
                       input int rd, input bit we, input bit ld, input bit st, input bit adv);
    dx_valid    = v;
    dx_rs       = {ADDR_W'(rs1), ADDR_W'(rs0)};
    dx_rs_use   = use_;
    dx_rd       = ADDR_W'(rd);
    dx_we       = we;
    dx_is_load  = ld;
    dx_is_store = st;
    advance     = adv;
  endtask

  task automatic push(input int rd, input bit we, input bit ld, input bit st);
    drive(1, 0, 0, 2'b00, rd, we, ld, st, 1);
    step();
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearModel();
    step();
    reset = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b0;
    clearModel();
    #2;
    chk("reset fwd_sel", 32'(fwd_sel), 32'h0);
    chk("reset stall",   32'(stall),   32'h0);
    chk("reset mem_fwd", 32'(mem_fwd), 32'h0);
    step();
    reset   = 1'b1;
    checkEn = 1;

    // add r3 in entry 1, D/X reads r3 on source 0
    push(3, 1, 0, 0);
    drive(1, 3, 0, 2'b01, 4, 1, 0, 0, 0);
    #1;
    chk("fwd r3 stage1", 32'(fwd_sel), 32'h1);
    chk("fwd r3 no stall", 32'(stall), 32'h0);

    // r3 writers in entries 1 and 2: youngest wins on both sources
    doReset();
    push(3, 1, 0, 0);
    push(3, 1, 0, 0);
    drive(1, 3, 3, 2'b11, 4, 1, 0, 0, 0);
    #1;
    chk("youngest wins", 32'(fwd_sel), 32'h5);

    // lw r5 then use on source 1: one stall cycle, then select stage 2
    doReset();
    push(5, 1, 1, 0);
    drive(1, 0, 5, 2'b10, 9, 1, 0, 0, 1);
    #1;
    chk("load-use stall",  32'(stall),   32'h1);
    chk("load-use bubble", 32'(bubble),  32'h1);
    chk("load-use sel 0",  32'(fwd_sel), 32'h0);
    step();
    chk("after stall",     32'(stall),   32'h0);
    chk("after stall sel", 32'(fwd_sel), 32'h8);
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt one", stall_cnt, 32'd1);
`endif
    step();

    // r0 is never forwarded
    doReset();
    push(0, 1, 0, 0);
    drive(1, 0, 0, 2'b11, 4, 1, 0, 0, 0);
    #1;
    chk("r0 sel",   32'(fwd_sel), 32'h0);
    chk("r0 stall", 32'(stall),   32'h0);

    // store-data forwarding from stage 2
    doReset();
    push(7, 1, 0, 0);
    push(7, 0, 0, 1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk("mem_fwd r7", 32'(mem_fwd), 32'h1);
    doReset();
    push(8, 1, 0, 0);
    push(7, 0, 0, 1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk("mem_fwd r8/r7", 32'(mem_fwd), 32'h0);

    // load-use stall frozen by advance=0, reset pulsed in the second cycle
    doReset();
    push(5, 1, 1, 0);
    drive(1, 0, 5, 2'b10, 9, 1, 0, 0, 0);
    #1;
    chk("frozen stall c1", 32'(stall), 32'h1);
    step();
    chk("frozen stall c2", 32'(stall), 32'h1);
    reset = 1'b0;
    clearModel();
    #1;
    chk("rst stall",   32'(stall),   32'h0);
    chk("rst bubble",  32'(bubble),  32'h0);
    chk("rst fwd_sel", 32'(fwd_sel), 32'h0);
    chk("rst mem_fwd", 32'(mem_fwd), 32'h0);
    reset = 1'b1;
    step();
    drive(1, 0, 5, 2'b10, 9, 1, 0, 0, 1);
    #1;
    chk("post-rst sel",   32'(fwd_sel), 32'h0);
    chk("post-rst stall", 32'(stall),   32'h0);
    step();
    push(6, 1, 1, 0);
    drive(1, 6, 0, 2'b01, 9, 1, 0, 0, 0);
    #1;
    chk("post-rst in RUN", 32'(stall), 32'h1);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int kind;
      if ($urandom_range(0, 299) == 0) doReset();
      kind = $urandom_range(0, 3);
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 7),
            kind < 2, kind == 1, kind == 2, $urandom_range(0, 3) != 0);
      step();
    end

    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
